id_pipe_ctrl: RTL

Decode-side partner of the instruction-fetch stage. It consumes the fetch stage's `PC` and `Instruction` into an IF/ID pipeline register and drives the fetch-control signals back to it:
- `PCWrite` for load-use stalls.
- `Branch` and `BranchAddr` for redirects on taken branches and jumps resolved in ID.

It sits between the fetch pipe and the ID/EX register. It owns stall insertion and wrong-path flushing.

---
 rtl/riscv_pkg.sv | 40 ++++
 rtl/branch_unit.sv | 58 +++++
 rtl/id_pipe_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I decode constants and immediate-extraction helpers.
//   opcode_e      - major opcodes used by ID-stage control
//   F3_*          - branch funct3 condition selects
//   NOP_INSTR     - canonical NOP (addi x0,x0,0)
//   imm_i/b/j()   - sign-extended 32-bit immediates for the I, B and J formats
package riscv_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/branch_unit.sv
// branch_unit: combinational branch/jump resolution for the instruction in ID.
//   id_pc     in   PC of the ID instruction
//   id_instr  in   ID instruction
//   rs1_data  in   forwarded rs1 value
//   rs2_data  in   forwarded rs2 value
//   taken     out  instruction is a taken branch, JAL or JALR
//   target    out  redirect target, wraps modulo 2^PC_W
module branch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned PC_W = 12
) (
  input  logic [PC_W-1:0] id_pc,
  input  logic [31:0]     id_instr,
  input  logic [31:0]     rs1_data,
  input  logic [31:0]     rs2_data,
  output logic            taken,
  output logic [PC_W-1:0] target
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = id_instr[6:0];
  assign funct3 = id_instr[14:12];

  // Targets are formed directly in PC_W bits; the dropped upper bits cannot
  // affect the low bits of a sum, so this matches the modulo-2^PC_W wrap.
  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (opcode)
      OP_JAL: begin
        taken  = 1'b1;
        target = id_pc + PC_W'(imm_j(id_instr));
      end
      OP_JALR: begin
        taken     = 1'b1;
        target    = PC_W'(rs1_data) + PC_W'(imm_i(id_instr));
        target[0] = 1'b0;
      end
      OP_BRANCH: begin
        target = id_pc + PC_W'(imm_b(id_instr));
        case (funct3)
          F3_BEQ:  taken = (rs1_data == rs2_data);
          F3_BNE:  taken = (rs1_data != rs2_data);
          F3_BLT:  taken = ($signed(rs1_data) <  $signed(rs2_data));
          F3_BGE:  taken = ($signed(rs1_data) >= $signed(rs2_data));
          F3_BLTU: taken = (rs1_data <  rs2_data);
          F3_BGEU: taken = (rs1_data >= rs2_data);
          default: taken = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_pipe_ctrl.sv
// id_pipe_ctrl: IF/ID pipeline register plus decode-side fetch control.
// Captures fetch PC/Instruction, detects load-use hazards, resolves branches
// and jumps in ID, and drives PCWrite/Branch/BranchAddr back to fetch.
//   clk, rst                  clock, synchronous active-high reset
//   PC, Instruction           fetch-stage PC and instruction
//   ex_mem_read, ex_rd        EX-stage load flag and destination register
//   rs1_data, rs2_data        forwarded operands of id_instr
//   id_valid, id_pc, id_instr IF/ID register contents (NOP when invalid)
//   id_stall                  load-use stall, ID/EX inserts a bubble
//   Branch, BranchAddr        fetch redirect and target (0 when no redirect)
//   PCWrite                   fetch PC update enable
//   stall_cnt, flush_cnt      perf counters, built only with ID_PERF_CNT_EN
//                             defined; tied to 0 otherwise
module id_pipe_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned PC_W    = 12,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    PC,
  input  logic [INSTR_W-1:0] Instruction,
  input  logic               ex_mem_read,
  input  logic [4:0]         ex_rd,
  input  logic [31:0]        rs1_data,
  input  logic [31:0]        rs2_data,
  output logic               id_valid,
  output logic [PC_W-1:0]    id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic               id_stall,
  output logic               Branch,
  output logic [PC_W-1:0]    BranchAddr,
  output logic               PCWrite,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
);

  logic               id_valid_q, id_valid_d;
  logic [PC_W-1:0]    id_pc_q,    id_pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;

  logic [6:0]      opcode;
  logic [4:0]      rs1, rs2;
  logic            uses_rs1, uses_rs2;
  logic            bu_taken;
  logic [PC_W-1:0] bu_target;

  assign opcode = id_instr_q[6:0];
  assign rs1    = id_instr_q[19:15];
  assign rs2    = id_instr_q[24:20];

  // U-type and JAL have no rs1 field; only R/S/B formats read rs2.
  assign uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign uses_rs2 = (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  assign id_stall = id_valid_q && ex_mem_read && (ex_rd != 5'd0) &&
                    ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));

  branch_unit #(
    .PC_W (PC_W)
  ) u_branch_unit (
    .id_pc    (id_pc_q),
    .id_instr (id_instr_q[31:0]),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .taken    (bu_taken),
    .target   (bu_target)
  );

  // A stalled branch waits: its operands may still depend on the load.
  assign Branch     = id_valid_q && !id_stall && bu_taken;
  assign BranchAddr = Branch ? bu_target : '0;
  assign PCWrite    = !id_stall;

  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    if (Branch) begin
      id_valid_d = 1'b0;
      id_pc_d    = PC;
      id_instr_d = INSTR_W'(NOP_INSTR);
    end else if (PCWrite) begin
      id_valid_d = 1'b1;
      id_pc_d    = PC;
      id_instr_d = Instruction;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= INSTR_W'(NOP_INSTR);
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;

`ifdef ID_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (id_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 16'd1;
    if (Branch   && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
